// File: rtl/display_timing_pkg.sv
// Shared display timing constants and lock-state encoding.
// The timing generator and sync_decoder use the same constants.
package display_timing_pkg;

  localparam int H_ACTIVE_DEFAULT = 320;
  localparam int V_ACTIVE_DEFAULT = 256;
  localparam int COORD_W          = 9;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

  // Coordinate and line counters stick at all-ones instead of wrapping.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by an edge-detect flop.
// en_i gates the edge flop, so rise/fall compare against the last enabled sample.
module edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      if (en_i) prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/sync_decoder.sv
// Recovers pixel strobes, X/Y coordinates and frame lock from a display timing stream.
//   state   | meaning
//   SEEK    | waiting for a VS rising edge to start measuring
//   MEASURE | counting one full frame, aborts on line error or timeout
//   LOCKED  | geometry confirmed, drops on any error
module sync_decoder
  import display_timing_pkg::*;
#(
  parameter int H_ACTIVE       = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE       = V_ACTIVE_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               in_main_clock,
  input  logic               in_reset_n,
  input  logic               in_display_clock,
  input  logic               in_display_hs,
  input  logic               in_display_vs,
  output logic               out_pixel_valid,
  output logic [COORD_W-1:0] out_coord_x,
  output logic [COORD_W-1:0] out_coord_y,
  output logic               out_locked,
  output logic [COORD_W-1:0] out_line_length,
  output logic [COORD_W-1:0] out_frame_lines,
  output logic               out_error
);

  localparam int                 WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]    WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [COORD_W-1:0] H_EXP    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_EXP    = COORD_W'(V_ACTIVE);

  logic strobe;
  logic dclk_level_unused, dclk_fall_unused, hs_rise_unused;
  logic hs, hs_fall_s, vs, vs_rise_s, vs_fall_s;

  edge_sync u_clk_sync (
    .clk_i  (in_main_clock),
    .rst_ni (in_reset_n),
    .en_i   (1'b1),
    .d_i    (in_display_clock),
    .level_o(dclk_level_unused),
    .rise_o (strobe),
    .fall_o (dclk_fall_unused)
  );

  // HS/VS edge flops advance only on strobes: edges are strobe-to-strobe.
  edge_sync u_hs_sync (
    .clk_i  (in_main_clock),
    .rst_ni (in_reset_n),
    .en_i   (strobe),
    .d_i    (in_display_hs),
    .level_o(hs),
    .rise_o (hs_rise_unused),
    .fall_o (hs_fall_s)
  );

  edge_sync u_vs_sync (
    .clk_i  (in_main_clock),
    .rst_ni (in_reset_n),
    .en_i   (strobe),
    .d_i    (in_display_vs),
    .level_o(vs),
    .rise_o (vs_rise_s),
    .fall_o (vs_fall_s)
  );

  logic               hs_fall, vs_rise, vs_fall, pix_hit;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, frame_total;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               line_err, frame_err, timeout;

  logic               pixel_valid_q, error_q, locked_q;
  logic [COORD_W-1:0] coord_x_q, coord_y_q, line_length_q, frame_lines_q;
  lock_state_e        state_q;

  assign hs_fall = strobe & hs_fall_s;
  assign vs_rise = strobe & vs_rise_s;
  assign vs_fall = strobe & vs_fall_s;
  assign pix_hit = strobe & hs & vs;

  // A line ending on the same strobe as the frame still belongs to that frame.
  assign frame_total = hs_fall ? sat_inc(y_q) : y_q;

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    wd_d      = wd_q;
    line_err  = 1'b0;
    frame_err = 1'b0;
    timeout   = 1'b0;
    if (strobe) begin
      wd_d = '0;
      x_d  = hs ? sat_inc(x_q) : '0;
      if (hs_fall && vs) begin
        y_d      = sat_inc(y_q);
        line_err = (x_q != H_EXP);
      end
      if (!vs) y_d = '0;
      if (vs_fall) frame_err = (frame_total != V_EXP);
    end else if (wd_q != WD_LIMIT) begin
      wd_d    = wd_q + 1'b1;
      timeout = (wd_d == WD_LIMIT);
    end
  end

  always_ff @(posedge in_main_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      wd_q          <= '0;
      pixel_valid_q <= 1'b0;
      coord_x_q     <= '0;
      coord_y_q     <= '0;
      line_length_q <= '0;
      frame_lines_q <= '0;
      error_q       <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      wd_q          <= wd_d;
      pixel_valid_q <= pix_hit;
      if (pix_hit) begin
        coord_x_q <= x_q;
        coord_y_q <= y_q;
      end
      if (hs_fall) line_length_q <= x_q;
      if (vs_fall) frame_lines_q <= frame_total;
      error_q <= line_err | frame_err | timeout;
    end
  end

  always_ff @(posedge in_main_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q  <= SEEK;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        SEEK: begin
          locked_q <= 1'b0;
          if (vs_rise) state_q <= MEASURE;
        end
        MEASURE: begin
          if (line_err || timeout) begin
            state_q  <= SEEK;
            locked_q <= 1'b0;
          end else if (vs_fall && !frame_err) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (line_err || frame_err || timeout) begin
            state_q  <= SEEK;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= SEEK;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_pixel_valid = pixel_valid_q;
  assign out_coord_x     = coord_x_q;
  assign out_coord_y     = coord_y_q;
  assign out_locked      = locked_q;
  assign out_line_length = line_length_q;
  assign out_frame_lines = frame_lines_q;
  assign out_error       = error_q;

endmodule

// File: tb/tb_sync_decoder.sv
// Directed bench for sync_decoder on a scaled-down 8x4 active raster, display clock = main/4.
module tb_sync_decoder;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dclk = 1'b0;
  logic       dhs = 1'b0;
  logic       dvs = 1'b0;
  logic       pv, locked, err;
  logic [8:0] cx, cy, llen, flines;

  int checks = 0;
  int failures = 0;

  int         pv_total = 0;
  int         err_total = 0;
  int         pv_double = 0;
  logic       pv_prev = 1'b0;
  logic [8:0] last_x = '0;
  logic [8:0] last_y = '0;

  always #5 clk = ~clk;

  sync_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT_CYCLES(TO)) dut (
    .in_main_clock   (clk),
    .in_reset_n      (rst_n),
    .in_display_clock(dclk),
    .in_display_hs   (dhs),
    .in_display_vs   (dvs),
    .out_pixel_valid (pv),
    .out_coord_x     (cx),
    .out_coord_y     (cy),
    .out_locked      (locked),
    .out_line_length (llen),
    .out_frame_lines (flines),
    .out_error       (err)
  );

  always @(negedge clk) begin
    if (pv) begin
      pv_total = pv_total + 1;
      last_x   = cx;
      last_y   = cy;
      if (pv_prev) pv_double = pv_double + 1;
    end
    if (err) err_total = err_total + 1;
    pv_prev = pv;
  end

  // One display pixel: 2 main cycles low, then 2 high; HS/VS change with the low phase.
  task automatic pix(input logic h, input logic v);
    @(negedge clk); dclk = 1'b0; dhs = h; dvs = v;
    @(negedge clk);
    @(negedge clk); dclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_line(input int len);
    for (int i = 0; i < len; i++) pix(1'b1, 1'b1);
    repeat (3) pix(1'b0, 1'b1);
  endtask

  task automatic send_vblank();
    repeat (22) pix(1'b0, 1'b0);
  endtask

  task automatic send_frame(input int lines);
    for (int l = 0; l < lines; l++) send_line(H);
    send_vblank();
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; dclk = 1'b0; dhs = 1'b0; dvs = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pv !== 1'b0)     begin failures++; $display("FAIL rst_pixel_valid got=%0d exp=0", pv); end
    checks++; if (err !== 1'b0)    begin failures++; $display("FAIL rst_error got=%0d exp=0", err); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%0d exp=0", locked); end
    checks++; if (cx !== 9'd0)     begin failures++; $display("FAIL rst_coord_x got=%0d exp=0", cx); end
    checks++; if (cy !== 9'd0)     begin failures++; $display("FAIL rst_coord_y got=%0d exp=0", cy); end
    checks++; if (llen !== 9'd0)   begin failures++; $display("FAIL rst_line_length got=%0d exp=0", llen); end
    checks++; if (flines !== 9'd0) begin failures++; $display("FAIL rst_frame_lines got=%0d exp=0", flines); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int p0, e0;
    p0 = pv_total; e0 = err_total;
    pix(1'b1, 1'b1);
    settle(2);
    checks++; if (cx !== 9'd0 || cy !== 9'd0) begin failures++; $display("FAIL nom_first_coord got=(%0d,%0d) exp=(0,0)", cx, cy); end
    checks++; if (pv_total - p0 !== 1) begin failures++; $display("FAIL nom_first_strobe got=%0d exp=1", pv_total - p0); end
    repeat (H - 1) pix(1'b1, 1'b1);
    repeat (3) pix(1'b0, 1'b1);
    for (int l = 1; l < V; l++) send_line(H);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL nom_locked_before_vs_fall got=%0d exp=0", locked); end
    send_vblank();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL nom_locked got=%0d exp=1", locked); end
    checks++; if (pv_total - p0 !== H * V) begin failures++; $display("FAIL nom_strobes got=%0d exp=%0d", pv_total - p0, H * V); end
    checks++; if (last_x !== 9'd7 || last_y !== 9'd3) begin failures++; $display("FAIL nom_last_coord got=(%0d,%0d) exp=(7,3)", last_x, last_y); end
    checks++; if (llen !== 9'd8)   begin failures++; $display("FAIL nom_line_length got=%0d exp=8", llen); end
    checks++; if (flines !== 9'd4) begin failures++; $display("FAIL nom_frame_lines got=%0d exp=4", flines); end
    p0 = pv_total;
    send_frame(V);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL nom2_locked got=%0d exp=1", locked); end
    checks++; if (pv_total - p0 !== H * V) begin failures++; $display("FAIL nom2_strobes got=%0d exp=%0d", pv_total - p0, H * V); end
    checks++; if (err_total - e0 !== 0) begin failures++; $display("FAIL nom_errors got=%0d exp=0", err_total - e0); end
  endtask

  task automatic test_simultaneous_fall();
    int e0;
    e0 = err_total;
    for (int l = 0; l < V - 1; l++) send_line(H);
    repeat (H) pix(1'b1, 1'b1);
    send_vblank();
    checks++; if (flines !== 9'd4) begin failures++; $display("FAIL simfall_frame_lines got=%0d exp=4", flines); end
    checks++; if (llen !== 9'd8)   begin failures++; $display("FAIL simfall_line_length got=%0d exp=8", llen); end
    checks++; if (err_total - e0 !== 0) begin failures++; $display("FAIL simfall_errors got=%0d exp=0", err_total - e0); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL simfall_locked got=%0d exp=1", locked); end
  endtask

  task automatic test_short_line();
    int e0;
    e0 = err_total;
    send_line(H);
    send_line(H - 1);
    checks++; if (llen !== 9'd7)   begin failures++; $display("FAIL shortline_line_length got=%0d exp=7", llen); end
    checks++; if (err_total - e0 !== 1) begin failures++; $display("FAIL shortline_errors got=%0d exp=1", err_total - e0); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL shortline_locked got=%0d exp=0", locked); end
    send_line(H);
    send_line(H);
    send_vblank();
    checks++; if (flines !== 9'd4) begin failures++; $display("FAIL shortline_frame_lines got=%0d exp=4", flines); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL shortline_seek_frame_locked got=%0d exp=0", locked); end
    send_frame(V);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL shortline_relock got=%0d exp=1", locked); end
    checks++; if (err_total - e0 !== 1) begin failures++; $display("FAIL shortline_total_errors got=%0d exp=1", err_total - e0); end
  endtask

  task automatic test_short_frame();
    int e0;
    do_reset();
    e0 = err_total;
    send_frame(V - 1);
    checks++; if (flines !== 9'd3) begin failures++; $display("FAIL shortframe_frame_lines got=%0d exp=3", flines); end
    checks++; if (err_total - e0 !== 1) begin failures++; $display("FAIL shortframe_errors got=%0d exp=1", err_total - e0); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL shortframe_locked got=%0d exp=0", locked); end
    send_frame(V);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL shortframe_relock got=%0d exp=1", locked); end
  endtask

  task automatic test_timeout();
    int   e0, n;
    bit   found;
    logic lk_prev;
    e0 = err_total; found = 1'b0; n = 0; lk_prev = locked;
    // Last strobe registers 2 edges after send_frame returns; the 64th idle edge after it raises the error.
    for (int i = 1; i <= 100 && !found; i++) begin
      @(negedge clk);
      if (err) begin found = 1'b1; n = i; end
      else lk_prev = locked;
    end
    checks++; if (!found)    begin failures++; $display("FAIL timeout_seen got=0 exp=1"); end
    checks++; if (n !== 66)  begin failures++; $display("FAIL timeout_cycle got=%0d exp=66", n); end
    checks++; if (locked !== 1'b0 || lk_prev !== 1'b1) begin failures++; $display("FAIL timeout_lock_drop got=%0d->%0d exp=1->0", lk_prev, locked); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width got=%0d exp=0", err); end
    repeat (80) @(negedge clk);
    #1;
    checks++; if (err_total - e0 !== 1) begin failures++; $display("FAIL timeout_hold got=%0d exp=1", err_total - e0); end
    send_frame(V);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL timeout_relock got=%0d exp=1", locked); end
    checks++; if (err_total - e0 !== 1) begin failures++; $display("FAIL timeout_total_errors got=%0d exp=1", err_total - e0); end
  endtask

  task automatic test_reset_midline();
    int p0;
    repeat (5) pix(1'b1, 1'b1);
    settle(2);
    checks++; if (cx !== 9'd4) begin failures++; $display("FAIL midline_pre_reset_x got=%0d exp=4", cx); end
    @(negedge clk); rst_n = 1'b0; dclk = 1'b0; dhs = 1'b0; dvs = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midline_locked got=%0d exp=0", locked); end
    checks++; if (cx !== 9'd0 || cy !== 9'd0) begin failures++; $display("FAIL midline_coord got=(%0d,%0d) exp=(0,0)", cx, cy); end
    checks++; if (llen !== 9'd0 || flines !== 9'd0) begin failures++; $display("FAIL midline_geometry got=(%0d,%0d) exp=(0,0)", llen, flines); end
    checks++; if (pv !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL midline_strobes got=(%0d,%0d) exp=(0,0)", pv, err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_vblank();
    p0 = pv_total;
    pix(1'b1, 1'b1);
    settle(2);
    checks++; if (cx !== 9'd0 || cy !== 9'd0) begin failures++; $display("FAIL midline_first_coord got=(%0d,%0d) exp=(0,0)", cx, cy); end
    checks++; if (pv_total - p0 !== 1) begin failures++; $display("FAIL midline_first_strobe got=%0d exp=1", pv_total - p0); end
    repeat (H - 1) pix(1'b1, 1'b1);
    repeat (3) pix(1'b0, 1'b1);
    for (int l = 1; l < V; l++) send_line(H);
    send_vblank();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL midline_relock got=%0d exp=1", locked); end
  endtask

  task automatic test_saturate();
    int e0, p0;
    e0 = err_total; p0 = pv_total;
    repeat (600) pix(1'b1, 1'b1);
    repeat (3) pix(1'b0, 1'b1);
    checks++; if (llen !== 9'd511) begin failures++; $display("FAIL sat_line_length got=%0d exp=511", llen); end
    checks++; if (err_total - e0 !== 1) begin failures++; $display("FAIL sat_errors got=%0d exp=1", err_total - e0); end
    checks++; if (last_x !== 9'd511 || last_y !== 9'd0) begin failures++; $display("FAIL sat_last_coord got=(%0d,%0d) exp=(511,0)", last_x, last_y); end
    checks++; if (pv_total - p0 !== 600) begin failures++; $display("FAIL sat_strobes got=%0d exp=600", pv_total - p0); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sat_locked got=%0d exp=0", locked); end
    send_vblank();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_simultaneous_fall();
    test_short_line();
    test_short_frame();
    test_timeout();
    test_reset_midline();
    test_saturate();
    checks++; if (pv_double !== 0) begin failures++; $display("FAIL pixel_valid_width got=%0d exp=0", pv_double); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
